// File: rtl/vsmp_prog_loader.sv
// Serial program writer: receives 8N1 framed bytes on RXD and fills the four VSMP program images.
// Optional even-parity bit (11-bit frame, PAR_ERR output) when VSMP_LOADER_PARITY_EN is defined.
module vsmp_prog_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       LOAD_CLR,
  output logic [7:0] MEME1,
  output logic [7:0] MEME2,
  output logic [7:0] MEME3,
  output logic [7:0] MEME4,
  output logic       BYTE_STROBE,
  output logic [1:0] BYTE_IDX,
  output logic       LOAD_DONE,
  output logic       CPU_HOLD,
`ifdef VSMP_LOADER_PARITY_EN
  output logic       PAR_ERR,
`endif
  output logic       FRAME_ERR
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef VSMP_LOADER_PARITY_EN
    PARITY,
`endif
    STOP,
    WRITE
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [TW-1:0]          tick_reg, tick_next;
  logic [2:0]             bitcnt_reg, bitcnt_next;
  logic [7:0]             shift_reg, shift_next;
  logic                   break_reg, break_next;
  logic                   frame_err_reg, frame_err_next;
  logic [7:0]             image_reg [4];
  logic [1:0]             idx_reg;
  logic                   done_reg;
  logic                   rxs;
  logic                   tick_zero;
`ifdef VSMP_LOADER_PARITY_EN
  logic                   par_bad_reg, par_bad_next;
  logic                   par_err_reg, par_err_next;
`endif

  assign rxs       = sync_reg[SYNC_STAGES-1];
  assign tick_zero = (tick_reg == '0);

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    bitcnt_next    = bitcnt_reg;
    shift_next     = shift_reg;
    break_next     = break_reg;
    frame_err_next = 1'b0;
`ifdef VSMP_LOADER_PARITY_EN
    par_bad_next   = par_bad_reg;
    par_err_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // After a line-low break the line must return high before a new start can arm.
        if (rxs) begin
          break_next = 1'b0;
        end else if (!break_reg) begin
          state_next = START;
          tick_next  = HALF_LOAD;
        end
      end
      START: begin
        if (!tick_zero) begin
          tick_next = tick_reg - TW'(1);
        end else if (rxs) begin
          state_next = IDLE;
        end else begin
          state_next  = DATA;
          bitcnt_next = 3'd0;
          tick_next   = FULL_LOAD;
        end
      end
      DATA: begin
        if (!tick_zero) begin
          tick_next = tick_reg - TW'(1);
        end else begin
          shift_next[bitcnt_reg] = rxs;
          tick_next              = FULL_LOAD;
          if (bitcnt_reg == 3'd7) begin
`ifdef VSMP_LOADER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bitcnt_next = bitcnt_reg + 3'd1;
          end
        end
      end
`ifdef VSMP_LOADER_PARITY_EN
      PARITY: begin
        if (!tick_zero) begin
          tick_next = tick_reg - TW'(1);
        end else begin
          par_bad_next = (^shift_reg) ^ rxs;
          tick_next    = FULL_LOAD;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick_zero) begin
          tick_next = tick_reg - TW'(1);
        end else begin
          state_next = IDLE;
          if (!rxs) begin
            frame_err_next = 1'b1;
            break_next     = 1'b1;
          end else begin
            state_next = WRITE;
          end
`ifdef VSMP_LOADER_PARITY_EN
          if (par_bad_reg) begin
            par_err_next = 1'b1;
            state_next   = IDLE;
          end
`endif
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (LOAD_CLR) state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      sync_reg      <= '1;
      tick_reg      <= '0;
      bitcnt_reg    <= 3'd0;
      shift_reg     <= 8'h00;
      break_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      idx_reg       <= 2'd0;
      done_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) image_reg[i] <= 8'h00;
`ifdef VSMP_LOADER_PARITY_EN
      par_bad_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], RXD};
      tick_reg      <= tick_next;
      bitcnt_reg    <= bitcnt_next;
      shift_reg     <= shift_next;
      break_reg     <= break_next;
      frame_err_reg <= frame_err_next;
`ifdef VSMP_LOADER_PARITY_EN
      par_bad_reg   <= par_bad_next;
      par_err_reg   <= par_err_next;
`endif
      // LOAD_CLR outranks a coincident WRITE: the byte is dropped.
      if (LOAD_CLR) begin
        idx_reg  <= 2'd0;
        done_reg <= 1'b0;
      end else if (state_reg == WRITE) begin
        image_reg[idx_reg] <= shift_reg;
        idx_reg            <= idx_reg + 2'd1;
        done_reg           <= (idx_reg == 2'd3);
      end
    end
  end

  assign MEME1       = image_reg[0];
  assign MEME2       = image_reg[1];
  assign MEME3       = image_reg[2];
  assign MEME4       = image_reg[3];
  assign BYTE_STROBE = (state_reg == WRITE) && !LOAD_CLR && !RST;
  assign BYTE_IDX    = idx_reg;
  assign LOAD_DONE   = done_reg;
  assign CPU_HOLD    = ~done_reg;
  assign FRAME_ERR   = frame_err_reg;
`ifdef VSMP_LOADER_PARITY_EN
  assign PAR_ERR     = par_err_reg;
`endif

endmodule

// File: doc/vsmp_prog_loader.md
Name: vsmp_prog_loader

Overview:
- Serial program writer for the VSMP program memory: receives framed bytes on the single-bit serial input and writes them, in order, into the four 8-bit program-memory images that feed meme1..meme4.
- Holds the processor in hold until all four bytes are loaded, then releases it.
- Sits between the board serial pin (INPUT1) and the VSMP memory-image inputs.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range is an even value >= 4.
- SYNC_STAGES, 2, flip-flop stages in the RXD synchroniser; legal range >= 2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RXD  in  1  serial data; idles high; asynchronous to CLK.
- LOAD_CLR  in  1  synchronous restart of loading; byte index goes to 0; images are kept.
- MEME1  out  8  program byte 0 (instr[7:4], data[3:0]).
- MEME2  out  8  program byte 1.
- MEME3  out  8  program byte 2.
- MEME4  out  8  program byte 3.
- BYTE_STROBE  out  1  one-cycle pulse when a byte is written to an image.
- BYTE_IDX  out  2  index of the next image to be written.
- LOAD_DONE  out  1  high after all 4 bytes are written.
- CPU_HOLD  out  1  equals ~LOAD_DONE; holds the VSMP CU/phase counter.
- FRAME_ERR  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (RST=1 at a rising edge):
  - MEME1..4 = 8'h00, BYTE_IDX = 0, LOAD_DONE = 0, CPU_HOLD = 1.
  - BYTE_STROBE = 0, FRAME_ERR = 0, FSM = IDLE.
  - Synchroniser flops = 1 and bit counter = 0.
  - RST mid-frame aborts the frame; no image is written.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- The FSM acts only on the synchronised RXD (rxs), which lags the pin by SYNC_STAGES cycles.
- IDLE: when rxs = 0, go to START and load the tick counter with CLKS_PER_BIT/2-1.
- START: when the counter reaches 0, sample rxs (mid-bit).
  - rxs = 1: false start; return to IDLE with no error.
  - rxs = 0: go to DATA with bit count = 0 and the counter reloaded with CLKS_PER_BIT-1.
- DATA: when the counter reaches 0, sample rxs into the shift register at position [bitcnt], then reload the counter. After bit 7, go to STOP.
- STOP: when the counter reaches 0, sample rxs.
  - rxs = 1: go to WRITE.
  - rxs = 0: pulse FRAME_ERR for one cycle, discard the byte, leave BYTE_IDX unchanged, and go to IDLE. This is a line-low break; IDLE waits for rxs = 1 before arming a new start.
- WRITE (one cycle):
  - Image[BYTE_IDX] <= shift register; BYTE_STROBE = 1 in this cycle.
  - BYTE_IDX <= BYTE_IDX + 1, wrapping 3 -> 0.
  - If BYTE_IDX was 3, LOAD_DONE <= 1.
  - Return to IDLE.
- Latency: image contents and BYTE_STROBE are valid 1 cycle after the stop-bit sample edge.
- Reload after done: the first byte written while LOAD_DONE = 1 clears LOAD_DONE in the same WRITE cycle, so CPU_HOLD re-asserts. That byte goes to MEME1.
- LOAD_CLR:
  - BYTE_IDX <= 0 and LOAD_DONE <= 0, and any frame in progress is aborted to IDLE.
  - If LOAD_CLR and WRITE occur in the same cycle, LOAD_CLR wins and the byte is dropped.
  - RST has priority over LOAD_CLR.
- Images are written only in WRITE; they hold their value in every other state.

Optional Feature:
- Macro: VSMP_LOADER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit.
  - A mismatch pulses output PAR_ERR (1 bit, reset 0) for one cycle at the stop-bit sample, and the byte is discarded; BYTE_IDX is unchanged.
  - The frame is 11 bits long.
- Undefined: no PARITY state, no PAR_ERR port, and the frame is 10 bits.

Test Plan:
- Reset: hold RST for 3 cycles with RXD = 1 -> MEME1..4 = 00, BYTE_IDX = 0, CPU_HOLD = 1, LOAD_DONE = 0.
- Full load, CLKS_PER_BIT = 4: send 8'h15, 8'h23, 8'h30, 8'hF0.
  - MEME1 = 15, MEME2 = 23, MEME3 = 30, MEME4 = F0.
  - Exactly 4 BYTE_STROBE pulses.
  - LOAD_DONE = 1 and CPU_HOLD = 0 in the cycle after the 4th stop sample.
- False start: a 1-cycle low glitch on RXD (shorter than CLKS_PER_BIT/2) -> no strobe, no FRAME_ERR, FSM back in IDLE.
- Framing error: send 8'hA5 with stop bit = 0 -> one FRAME_ERR pulse, no strobe, BYTE_IDX unchanged. A following valid 8'hA5 is written to the same image.
- Reload/clear:
  - After a full load, send 8'h7C -> MEME1 = 7C, LOAD_DONE = 0, BYTE_IDX = 1.
  - Then assert LOAD_CLR during the DATA state of the next frame -> frame dropped, BYTE_IDX = 0, MEME2 unchanged.
- Parity (macro defined): send 8'h03 with parity = 1 -> PAR_ERR pulses once and MEME1 is unchanged. Resend with parity = 0 -> MEME1 = 03.
